// File: rtl/icache_stage2.sv
`default_nettype none
// ---------------------------------------------------------------------------
// icache_stage2 : tag compare, word select and single-line miss refill
// Optional ICACHE_PERF_CNT_EN adds saturating HitCnt/MissCnt.  Rev 1.0
// ---------------------------------------------------------------------------
module icache_stage2 #(
  parameter int ADDR_W  = 32,
  parameter int LINE_W  = 512,
  parameter int TAG_W   = 20,
  parameter int INDEX_W = 6
) (
  input  logic               Clk,
  input  logic               Rest,
  input  logic               Flush,
  input  logic               DownStop,
  input  logic               InAble,
  input  logic [ADDR_W-1:0]  InPc,
  input  logic [5:0]         InOffset,
  input  logic [LINE_W-1:0]  InWay1Date,
  input  logic [LINE_W-1:0]  InWay2Date,
  input  logic [LINE_W-1:0]  InWay3Date,
  input  logic [LINE_W-1:0]  InWay4Date,
  input  logic [TAG_W-1:0]   InWay1Tag,
  input  logic [TAG_W-1:0]   InWay2Tag,
  input  logic [TAG_W-1:0]   InWay3Tag,
  input  logic [TAG_W-1:0]   InWay4Tag,
  output logic               OutInstAble,
  output logic [ADDR_W-1:0]  OutPc,
  output logic [31:0]        OutInst,
  output logic               IcacheStopReq,
  output logic               HitAble,
  output logic [INDEX_W-1:0] HitIndex,
  output logic               HitWay1,
  output logic               HitWay2,
  output logic               HitWay3,
  output logic               HitWay4,
  output logic               NewAble,
  output logic [INDEX_W-1:0] NewIndex,
  output logic [TAG_W-1:0]   NewTag,
  output logic [LINE_W-1:0]  NewDate,
  output logic               MemReqValid,
  output logic [ADDR_W-1:0]  MemReqAddr,
  input  logic               MemReqReady,
  input  logic               MemRespValid,
  input  logic [LINE_W-1:0]  MemRespData
`ifdef ICACHE_PERF_CNT_EN
  ,
  output logic [31:0]        HitCnt,
  output logic [31:0]        MissCnt
`endif
);

  localparam int OFF_W = ADDR_W - TAG_W - INDEX_W;
  localparam int SEL_W = OFF_W - 2;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2,
    S_FILL = 2'd3
  } state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   miss_pc_q, miss_pc_d;
  logic [SEL_W-1:0]    miss_sel_q, miss_sel_d;
  logic [LINE_W-1:0]   line_q, line_d;
  logic                discard_q, discard_d;
  logic                out_valid_q, out_valid_d;
  logic [ADDR_W-1:0]   out_pc_q, out_pc_d;
  logic [31:0]         out_inst_q, out_inst_d;

  logic [TAG_W-1:0]    way_tag  [4];
  logic [LINE_W-1:0]   way_line [4];
  logic [TAG_W-1:0]    pc_tag;
  logic [INDEX_W-1:0]  pc_index;
  logic [3:0]          hit_onehot;
  logic [LINE_W-1:0]   hit_line;
  logic                any_hit, idle, hit_able, miss_launch;
  logic [31:0]         hit_word, fill_word;
  logic                unused_offset_bits;

  assign way_tag[0]  = InWay1Tag;
  assign way_tag[1]  = InWay2Tag;
  assign way_tag[2]  = InWay3Tag;
  assign way_tag[3]  = InWay4Tag;
  assign way_line[0] = InWay1Date;
  assign way_line[1] = InWay2Date;
  assign way_line[2] = InWay3Date;
  assign way_line[3] = InWay4Date;

  assign pc_tag   = InPc[ADDR_W-1 -: TAG_W];
  assign pc_index = InPc[ADDR_W-TAG_W-1 -: INDEX_W];

  // Scan from the top way down so the lowest matching way is the last writer.
  always_comb begin
    hit_onehot = '0;
    hit_line   = '0;
    for (int w = 3; w >= 0; w--) begin
      if (InAble && (way_tag[w] == pc_tag)) begin
        hit_onehot    = '0;
        hit_onehot[w] = 1'b1;
        hit_line      = way_line[w];
      end
    end
  end

  assign any_hit     = |hit_onehot;
  assign idle        = (state_q == S_IDLE);
  assign hit_able    = idle & ~DownStop & ~Flush & any_hit;
  assign miss_launch = idle & InAble & ~any_hit & ~Flush & ~DownStop;
  assign hit_word    = hit_line[{InOffset[OFF_W-1:2], 5'b0} +: 32];
  assign fill_word   = line_q[{miss_sel_q, 5'b0} +: 32];
  assign unused_offset_bits = ^InOffset[1:0];

  always_comb begin
    state_d     = state_q;
    miss_pc_d   = miss_pc_q;
    miss_sel_d  = miss_sel_q;
    line_d      = line_q;
    discard_d   = discard_q;
    out_valid_d = 1'b0;
    out_pc_d    = out_pc_q;
    out_inst_d  = out_inst_q;

    case (state_q)
      S_IDLE: begin
        discard_d = 1'b0;
        if (miss_launch) begin
          state_d    = S_REQ;
          miss_pc_d  = InPc;
          miss_sel_d = InOffset[OFF_W-1:2];
        end
      end
      S_REQ: begin
        if (Flush) discard_d = 1'b1;
        if (MemReqReady) state_d = S_WAIT;
      end
      S_WAIT: begin
        if (Flush) discard_d = 1'b1;
        if (MemRespValid) begin
          state_d = S_FILL;
          line_d  = MemRespData;
        end
      end
      S_FILL: begin
        state_d   = S_IDLE;
        discard_d = 1'b0;
      end
      default: state_d = S_IDLE;
    endcase

    // Refill delivery wins over a decode hold: outputs are never valid during a miss.
    if (Flush) begin
      out_valid_d = 1'b0;
    end else if (state_q == S_FILL) begin
      if (!discard_q) begin
        out_valid_d = 1'b1;
        out_pc_d    = miss_pc_q;
        out_inst_d  = fill_word;
      end
    end else if (DownStop) begin
      out_valid_d = out_valid_q;
    end else if (hit_able) begin
      out_valid_d = 1'b1;
      out_pc_d    = InPc;
      out_inst_d  = hit_word;
    end
  end

  always_ff @(posedge Clk) begin
    if (Rest) begin
      state_q     <= S_IDLE;
      miss_pc_q   <= '0;
      miss_sel_q  <= '0;
      line_q      <= '0;
      discard_q   <= 1'b0;
      out_valid_q <= 1'b0;
      out_pc_q    <= '0;
      out_inst_q  <= '0;
    end else begin
      state_q     <= state_d;
      miss_pc_q   <= miss_pc_d;
      miss_sel_q  <= miss_sel_d;
      line_q      <= line_d;
      discard_q   <= discard_d;
      out_valid_q <= out_valid_d;
      out_pc_q    <= out_pc_d;
      out_inst_q  <= out_inst_d;
    end
  end

  assign OutInstAble   = out_valid_q;
  assign OutPc         = out_pc_q;
  assign OutInst       = out_inst_q;
  assign IcacheStopReq = miss_launch | ~idle;
  assign HitAble       = hit_able;
  assign HitIndex      = hit_able ? pc_index : '0;
  assign {HitWay4, HitWay3, HitWay2, HitWay1} = hit_able ? hit_onehot : 4'b0000;
  assign NewAble       = (state_q == S_FILL);
  assign NewIndex      = miss_pc_q[ADDR_W-TAG_W-1 -: INDEX_W];
  assign NewTag        = miss_pc_q[ADDR_W-1 -: TAG_W];
  assign NewDate       = line_q;
  assign MemReqValid   = (state_q == S_REQ);
  assign MemReqAddr    = {miss_pc_q[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};

`ifdef ICACHE_PERF_CNT_EN
  logic [31:0] hit_cnt_q, hit_cnt_d, miss_cnt_q, miss_cnt_d;

  always_comb begin
    hit_cnt_d  = hit_cnt_q;
    miss_cnt_d = miss_cnt_q;
    if (hit_able && (hit_cnt_q != 32'hFFFF_FFFF)) hit_cnt_d = hit_cnt_q + 32'd1;
    if (miss_launch && (miss_cnt_q != 32'hFFFF_FFFF)) miss_cnt_d = miss_cnt_q + 32'd1;
  end

  always_ff @(posedge Clk) begin
    if (Rest) begin
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else begin
      hit_cnt_q  <= hit_cnt_d;
      miss_cnt_q <= miss_cnt_d;
    end
  end

  assign HitCnt  = hit_cnt_q;
  assign MissCnt = miss_cnt_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_icache_stage2.sv
`default_nettype none
// Randomized bench for icache_stage2 against a transaction-level reference model.
module tb_icache_stage2;

  logic         Clk = 1'b0;
  logic         Rest, Flush, DownStop, InAble;
  logic [31:0]  InPc;
  logic [5:0]   InOffset;
  logic [511:0] InWay1Date, InWay2Date, InWay3Date, InWay4Date;
  logic [19:0]  InWay1Tag, InWay2Tag, InWay3Tag, InWay4Tag;
  logic         OutInstAble;
  logic [31:0]  OutPc, OutInst;
  logic         IcacheStopReq, HitAble;
  logic [5:0]   HitIndex;
  logic         HitWay1, HitWay2, HitWay3, HitWay4;
  logic         NewAble;
  logic [5:0]   NewIndex;
  logic [19:0]  NewTag;
  logic [511:0] NewDate;
  logic         MemReqValid;
  logic [31:0]  MemReqAddr;
  logic         MemReqReady, MemRespValid;
  logic [511:0] MemRespData;

  always #5 Clk = ~Clk;

  icache_stage2 dut (
    .Clk(Clk), .Rest(Rest), .Flush(Flush), .DownStop(DownStop), .InAble(InAble),
    .InPc(InPc), .InOffset(InOffset),
    .InWay1Date(InWay1Date), .InWay2Date(InWay2Date), .InWay3Date(InWay3Date), .InWay4Date(InWay4Date),
    .InWay1Tag(InWay1Tag), .InWay2Tag(InWay2Tag), .InWay3Tag(InWay3Tag), .InWay4Tag(InWay4Tag),
    .OutInstAble(OutInstAble), .OutPc(OutPc), .OutInst(OutInst),
    .IcacheStopReq(IcacheStopReq), .HitAble(HitAble), .HitIndex(HitIndex),
    .HitWay1(HitWay1), .HitWay2(HitWay2), .HitWay3(HitWay3), .HitWay4(HitWay4),
    .NewAble(NewAble), .NewIndex(NewIndex), .NewTag(NewTag), .NewDate(NewDate),
    .MemReqValid(MemReqValid), .MemReqAddr(MemReqAddr), .MemReqReady(MemReqReady),
    .MemRespValid(MemRespValid), .MemRespData(MemRespData)
  );

  int total = 0;
  int bad   = 0;

  // Reference model: an outstanding miss walks through request, data wait, line write.
  bit           m_busy;
  int           m_phase;   // 0 request, 1 awaiting data, 2 writing line
  logic [31:0]  m_pc;
  logic [5:0]   m_off;
  logic [511:0] m_line;
  bit           m_drop;
  bit           e_valid;
  logic [31:0]  e_pc, e_inst;

  task automatic chk(input string tag, input logic [511:0] got, input logic [511:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] word_of(input logic [511:0] line, input logic [5:0] off);
    logic [511:0] sh;
    sh = line >> ((off / 4) * 32);
    return sh[31:0];
  endfunction

  function automatic logic [511:0] rand_line();
    logic [511:0] l;
    for (int i = 0; i < 16; i++) l[i*32 +: 32] = $urandom;
    return l;
  endfunction

  task automatic model_clear();
    m_busy = 0; m_phase = 0; m_pc = '0; m_off = '0; m_line = '0; m_drop = 0;
    e_valid = 0; e_pc = '0; e_inst = '0;
  endtask

  task automatic quiet_inputs();
    Rest = 0; Flush = 0; DownStop = 0; InAble = 0;
    MemReqReady = 0; MemRespValid = 0;
  endtask

  // Check one cycle against the model, advance the model, move to the next falling edge.
  task automatic step();
    logic [19:0]  tg[4];
    logic [511:0] ln[4];
    int  first;
    bit  e_hit, e_miss;
    #1;
    tg[0] = InWay1Tag;  tg[1] = InWay2Tag;  tg[2] = InWay3Tag;  tg[3] = InWay4Tag;
    ln[0] = InWay1Date; ln[1] = InWay2Date; ln[2] = InWay3Date; ln[3] = InWay4Date;
    first = -1;
    for (int w = 0; w < 4; w++)
      if (InAble && first < 0 && tg[w] == InPc[31:12]) first = w;
    e_hit  = !m_busy && !DownStop && !Flush && first >= 0;
    e_miss = !m_busy && InAble && first < 0 && !Flush && !DownStop;

    if (!Rest) begin
      chk("hit_able", HitAble, e_hit);
      chk("hit_way", {HitWay4, HitWay3, HitWay2, HitWay1}, e_hit ? (4'b0001 << first) : 4'b0000);
      chk("hit_index", HitIndex, e_hit ? InPc[11:6] : 6'd0);
      chk("stop_req", IcacheStopReq, e_miss || m_busy);
      chk("req_valid", MemReqValid, m_busy && m_phase == 0);
      if (m_busy && m_phase == 0) chk("req_addr", MemReqAddr, m_pc & 32'hFFFF_FFC0);
      chk("new_able", NewAble, m_busy && m_phase == 2);
      if (m_busy && m_phase == 2) begin
        chk("new_index", NewIndex, m_pc[11:6]);
        chk("new_tag", NewTag, m_pc[31:12]);
        chk("new_date", NewDate, m_line);
      end
      chk("out_valid", OutInstAble, e_valid);
      if (e_valid) begin
        chk("out_pc", OutPc, e_pc);
        chk("out_inst", OutInst, e_inst);
      end
    end

    if (Rest) begin
      model_clear();
    end else begin
      if (Flush) e_valid = 0;
      else if (m_busy && m_phase == 2) begin
        e_valid = !m_drop;
        if (!m_drop) begin e_pc = m_pc; e_inst = word_of(m_line, m_off); end
      end else if (DownStop) begin
        // hold everything
      end else if (e_hit) begin
        e_valid = 1; e_pc = InPc; e_inst = word_of(ln[first], InOffset);
      end else e_valid = 0;

      if (!m_busy) begin
        if (e_miss) begin
          m_busy = 1; m_phase = 0; m_pc = InPc; m_off = InOffset; m_drop = 0;
        end
      end else begin
        if (Flush) m_drop = 1;
        case (m_phase)
          0: if (MemReqReady) m_phase = 1;
          1: if (MemRespValid) begin m_line = MemRespData; m_phase = 2; end
          default: begin m_busy = 0; m_drop = 0; end
        endcase
      end
    end
    @(negedge Clk);
  endtask

  task automatic set_tags(input logic [19:0] t1, t2, t3, t4);
    InWay1Tag = t1; InWay2Tag = t2; InWay3Tag = t3; InWay4Tag = t4;
    InWay1Date = rand_line(); InWay2Date = rand_line();
    InWay3Date = rand_line(); InWay4Date = rand_line();
  endtask

  logic [19:0]  tag_pool[4];
  logic [511:0] resp;
  logic [31:0]  held;

  initial begin
    tag_pool[0] = 20'h1C000; tag_pool[1] = 20'h20000;
    tag_pool[2] = 20'hABCDE; tag_pool[3] = 20'h00001;
    model_clear();
    quiet_inputs();
    Rest = 1;
    InPc = '0; InOffset = '0; MemRespData = '0;
    set_tags(20'h0, 20'h0, 20'h0, 20'h0);
    @(negedge Clk);
    step(); step();
    Rest = 0;
    #1;
    chk("rst_out_valid", OutInstAble, 1'b0);
    chk("rst_out_pc", OutPc, 32'd0);
    chk("rst_out_inst", OutInst, 32'd0);
    chk("rst_stop", IcacheStopReq, 1'b0);
    chk("rst_new", {NewAble, NewIndex, NewTag}, 27'd0);
    chk("rst_req", {MemReqValid, MemReqAddr}, 33'd0);
    step();

    // Hit in way 3, word 2
    set_tags(20'h11111, 20'h22222, 20'h1C000, 20'h33333);
    InWay3Date[95:64] = 32'hDEADBEEF;
    InPc = 32'h1C000048; InOffset = 6'h08; InAble = 1;
    #1;
    chk("tp_hit_able", HitAble, 1'b1);
    chk("tp_hit_way3", {HitWay4, HitWay3, HitWay2, HitWay1}, 4'b0100);
    chk("tp_hit_index", HitIndex, 6'd1);
    step();
    InAble = 0;
    #1;
    chk("tp_hit_inst", OutInst, 32'hDEADBEEF);
    chk("tp_hit_pc", OutPc, 32'h1C000048);
    step();

    // Miss and refill
    set_tags(20'h11111, 20'h22222, 20'h33333, 20'h44444);
    InPc = 32'h20000F84; InOffset = 6'h04; InAble = 1;
    #1;
    chk("tp_miss_stop", IcacheStopReq, 1'b1);
    step();
    InAble = 0;
    #1;
    chk("tp_req_addr", MemReqAddr, 32'h20000F80);
    step();
    MemReqReady = 1; step(); MemReqReady = 0;
    step(); step(); step();
    resp = rand_line();
    MemRespValid = 1; MemRespData = resp; step(); MemRespValid = 0;
    #1;
    chk("tp_fill_new", {NewAble, NewIndex, NewTag}, {1'b1, 6'h3E, 20'h20000});
    chk("tp_fill_stop", IcacheStopReq, 1'b1);
    step();
    #1;
    chk("tp_fill_inst", OutInst, resp[63:32]);
    chk("tp_fill_stop_drop", IcacheStopReq, 1'b0);
    step();

    // Double tag match: lowest way wins
    set_tags(20'h1C000, 20'h22222, 20'h33333, 20'h1C000);
    InPc = 32'h1C000040; InOffset = 6'h00; InAble = 1;
    #1;
    chk("tp_double_way", {HitWay4, HitWay3, HitWay2, HitWay1}, 4'b0001);
    step();
    InAble = 0;
    step();

    // Flush while waiting for the line
    set_tags(20'h11111, 20'h22222, 20'h33333, 20'h44444);
    InPc = 32'h20000F84; InOffset = 6'h04; InAble = 1;
    step();
    InAble = 0; MemReqReady = 1; step(); MemReqReady = 0;
    Flush = 1; step(); Flush = 0;
    MemRespValid = 1; MemRespData = rand_line(); step(); MemRespValid = 0;
    #1;
    chk("tp_flush_new", NewAble, 1'b1);
    step();
    #1;
    chk("tp_flush_no_out", OutInstAble, 1'b0);
    chk("tp_flush_idle", IcacheStopReq, 1'b0);
    step();

    // Decode stall after a hit
    set_tags(20'h11111, 20'h1C000, 20'h33333, 20'h44444);
    InPc = 32'h1C00007C; InOffset = 6'h3C; InAble = 1;
    held = InWay2Date[511:480];
    step();
    DownStop = 1; InPc = 32'h5555_5000; InOffset = 6'h00;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("tp_stall_hold", {OutInstAble, OutInst, OutPc}, {1'b1, held, 32'h1C00007C});
      chk("tp_stall_quiet", {HitAble, MemReqValid, IcacheStopReq}, 3'b000);
      step();
    end
    DownStop = 0; InAble = 0;
    step();

    // Reset while waiting, then a stale response
    InPc = 32'h20000F84; InOffset = 6'h04; InAble = 1;
    step();
    InAble = 0; MemReqReady = 1; step(); MemReqReady = 0;
    Rest = 1; step(); Rest = 0;
    MemRespValid = 1; MemRespData = rand_line();
    #1;
    chk("tp_rst_quiet", {OutInstAble, IcacheStopReq, MemReqValid, NewAble, HitAble}, 5'b0);
    step();
    MemRespValid = 0;
    #1;
    chk("tp_rst_no_new", NewAble, 1'b0);
    step();

    // Randomized traffic
    for (int n = 0; n < 3000; n++) begin
      InPc = {tag_pool[$urandom_range(0, 3)], 6'($urandom), 6'($urandom)};
      InOffset = ($urandom_range(0, 7) == 0) ? 6'($urandom) : InPc[5:0];
      InWay1Tag = ($urandom_range(0, 2) == 0) ? InPc[31:12] : tag_pool[$urandom_range(0, 3)];
      InWay2Tag = ($urandom_range(0, 2) == 0) ? InPc[31:12] : tag_pool[$urandom_range(0, 3)];
      InWay3Tag = ($urandom_range(0, 2) == 0) ? InPc[31:12] : tag_pool[$urandom_range(0, 3)];
      InWay4Tag = ($urandom_range(0, 2) == 0) ? InPc[31:12] : tag_pool[$urandom_range(0, 3)];
      InWay1Date = rand_line(); InWay2Date = rand_line();
      InWay3Date = rand_line(); InWay4Date = rand_line();
      InAble       = ($urandom_range(0, 3) != 0);
      Flush        = ($urandom_range(0, 15) == 0);
      DownStop     = ($urandom_range(0, 3) == 0);
      MemReqReady  = ($urandom_range(0, 2) == 0);
      MemRespValid = ($urandom_range(0, 2) == 0);
      MemRespData  = rand_line();
      Rest         = ($urandom_range(0, 199) == 0);
      step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/icache_stage2.md
Name: icache_stage2

Overview:
Second pipeline stage of the instruction cache. It consumes the four way tags and 512-bit lines read by stage 1 for the registered fetch PC, compares tags, and selects the 32-bit instruction by offset. It reports hits back to stage 1 for the LRU counters. On a miss it stalls the front end, fetches the full line from memory, writes it into stage 1 via the new-line port, and delivers the missed instruction straight from the returned line.

Parameters:
ADDR_W, 32, PC width
LINE_W, 512, cache line width in bits (64 B)
TAG_W, 20, tag width = PC[31:12]
INDEX_W, 6, set index = PC[11:6]

Ports:
Clk  in  1  clock
Rest  in  1  synchronous active-high reset
Flush  in  1  front-end redirect; kills the in-flight fetch
DownStop  in  1  decode stall; holds outputs
InAble  in  1  stage-1 fetch valid
InPc  in  32  fetch PC
InOffset  in  6  byte offset in line
InWay1Date..InWay4Date  in  512 each  way lines
InWay1Tag..InWay4Tag  in  20 each  way tags
OutInstAble  out  1  instruction valid to decode
OutPc  out  32  PC of OutInst
OutInst  out  32  fetched instruction
IcacheStopReq  out  1  stall request to ictrl/stage 1
HitAble  out  1  hit report to stage 1 (LRU update)
HitIndex  out  6  PC[11:6] of the hit
HitWay1..HitWay4  out  1 each  one-hot hit way
NewAble  out  1  refill write strobe to stage 1
NewIndex  out  6  refill set
NewTag  out  20  refill tag
NewDate  out  512  refill line
MemReqValid  out  1  line read request
MemReqAddr  out  32  line-aligned address {PC[31:6],6'b0}
MemReqReady  in  1  memory accepts request
MemRespValid  in  1  single-beat line return
MemRespData  in  512  returned line

Behaviour:
- Reset values: all outputs 0; FSM in IDLE; miss PC register 0; discard flag 0.
- Hit check (combinational):
  - HitN = InAble & (InWayNTag == InPc[31:12]).
  - With multiple matches, the lowest way wins; HitWay* is always one-hot or zero.
- Instruction select: word = line[InOffset[5:2]*32 +: 32]. InOffset[1:0] is ignored.
- Hit path, IDLE & ~DownStop & ~Flush & hit:
  - HitAble=1 in the same cycle, with HitIndex/HitWay*.
  - Next cycle: OutInstAble=1, OutPc=InPc, OutInst=selected word. Latency is 1 cycle.
- Holding and empty cycles:
  - DownStop=1: Out* hold, HitAble=0, no miss launched.
  - Otherwise OutInstAble=0 in any cycle without a delivery.
- FSM states: IDLE, REQ, WAIT, FILL.
  - IDLE -> REQ on InAble & ~hit & ~Flush & ~DownStop. Latch InPc and InOffset.
  - REQ: MemReqValid=1, MemReqAddr held. Go to WAIT on MemReqReady.
  - WAIT: go to FILL when MemRespValid; latch MemRespData.
  - FILL, lasting one cycle:
    - NewAble=1 with NewIndex=PC[11:6], NewTag=PC[31:12], NewDate=line.
    - Next cycle: OutInstAble=1 with the selected word, unless discard is set.
    - -> IDLE.
- IcacheStopReq = (IDLE & miss condition) | (state != IDLE). It drops in the cycle after FILL, so stage 1 re-presents the next PC.
- Flush:
  - In IDLE: suppresses hit output and miss launch.
  - In REQ/WAIT/FILL: sets discard. The memory transaction still completes and the line is still written (NewAble=1), but no instruction is delivered. Discard clears on return to IDLE.
  - Also forces OutInstAble=0 on the next edge.
- NewAble and HitAble are never high in the same cycle.
- Rest mid-miss: FSM returns to IDLE immediately and MemReqValid drops. A late MemRespValid in IDLE is ignored.
- MemRespValid in IDLE or REQ: ignored.

Optional Feature:
ICACHE_PERF_CNT_EN
- Defined: adds outputs HitCnt[31:0] and MissCnt[31:0].
  - HitCnt increments on each HitAble pulse.
  - MissCnt increments on each IDLE->REQ.
  - Both saturate at 32'hFFFF_FFFF and clear on Rest.
- Undefined: ports and logic absent; behaviour is otherwise identical.

Test Plan:
- Hit way3: InPc=0x1C000048, InOffset=0x08, InWay3Tag=0x1C000, line word2=0xDEADBEEF -> HitAble=1, HitIndex=1, HitWay3=1 same cycle; next cycle OutInst=0xDEADBEEF, OutPc=0x1C000048.
- Miss and refill: InPc=0x20000F84, no tag match; MemReqReady after 2 cycles, resp after 5 -> MemReqAddr=0x20000F80; NewAble=1, NewIndex=0x3E, NewTag=0x20000; OutInst=word1 of response; IcacheStopReq high from the miss cycle through FILL.
- Double tag match on way1 and way4 -> only HitWay1=1.
- Flush during WAIT -> NewAble still pulses, OutInstAble stays 0, FSM returns to IDLE.
- DownStop=1 for 3 cycles after a hit -> OutInst/OutPc held, HitAble=0 throughout, no MemReqValid.
- Rest asserted in WAIT, then MemRespValid one cycle later -> all outputs 0, FSM in IDLE, no NewAble.
